// File: rtl/alu_control_sequencer.sv
// Hardwired T0-T6 control-step sequencer for the 3-bus datapath: fetch over a
// mem_ready handshake, decode IR, then drive the register ALU execute steps.
module alu_control_sequencer #(
  parameter int IRW    = 32,
  parameter int OPW    = 5,
  parameter int REGW   = 4,
  parameter int MEM_TO = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [IRW-1:0]       ir,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Zin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 HIin,
  output logic                 LOin,
  output logic [(2**REGW)-1:0] Rin,
  output logic [(2**REGW)-1:0] Rout,
  output logic                 alu_en,
  output logic [OPW-1:0]       alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 err
);

  localparam int NREG  = 2**REGW;
  localparam int CNTW  = $clog2(MEM_TO + 1);
  localparam int RA_HI = IRW - OPW - 1;
  localparam int RB_HI = RA_HI - REGW;
  localparam int RC_HI = RB_HI - REGW;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    CLS_BIN     = 2'd0,
    CLS_MULDIV  = 2'd1,
    CLS_UNARY   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_cls_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic hi_in;
    logic lo_in;
  } ctl_t;

  localparam ctl_t CTL_NONE = {$bits(ctl_t){1'b0}};

  function automatic op_cls_e classify(input logic [OPW-1:0] op);
    case (op)
      OPW'(3), OPW'(4), OPW'(5), OPW'(6),
      OPW'(7), OPW'(8), OPW'(9), OPW'(10): classify = CLS_BIN;
      OPW'(15), OPW'(16):                  classify = CLS_MULDIV;
      OPW'(17), OPW'(18):                  classify = CLS_UNARY;
      default:                             classify = CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [NREG-1:0] reg_sel(input logic [REGW-1:0] idx);
    reg_sel = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_e              state_r, state_next_s;
  logic [CNTW-1:0]     cnt_r, cnt_next_s;
  logic                timeout_s;
  ctl_t                ctl_r, ctl_next_s;
  logic [NREG-1:0]     rin_r, rin_next_s, rout_r, rout_next_s;
  logic                alu_en_r, alu_en_next_s;
  logic [OPW-1:0]      alu_op_r, alu_op_next_s;
  logic                busy_r, done_r, done_next_s;
  logic                illegal_r, illegal_next_s, err_r, err_next_s;
  logic [NREG-1:0]     t3_rout_s;
  logic                t3_yin_s;

  logic [OPW-1:0]      op_s;
  logic [REGW-1:0]     ra_s, rb_s, rc_s;
  op_cls_e             cls_s;
  logic                unused_ir_s;

  assign op_s        = ir[IRW-1 -: OPW];
  assign ra_s        = ir[RA_HI -: REGW];
  assign rb_s        = ir[RB_HI -: REGW];
  assign rc_s        = ir[RC_HI -: REGW];
  assign cls_s       = classify(op_s);
  assign unused_ir_s = ^ir[RC_HI-REGW:0];

  // Step sequencing and the T1 memory-wait timeout counter.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    timeout_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = S_T0;
        else       state_next_s = S_IDLE;
      end
      S_T0: begin
        state_next_s = S_T1;
        cnt_next_s   = {CNTW{1'b0}};
      end
      S_T1: begin
        if (mem_ready) begin
          state_next_s = S_T2;
        end else if (cnt_r == CNTW'(MEM_TO - 1)) begin
          state_next_s = S_IDLE;
          timeout_s    = 1'b1;
          cnt_next_s   = {CNTW{1'b0}};
        end else begin
          cnt_next_s = cnt_r + CNTW'(1);
        end
      end
      S_T2: state_next_s = S_T3;
      S_T3: begin
        if (cls_s == CLS_ILLEGAL) state_next_s = S_DONE;
        else                      state_next_s = S_T4;
      end
      S_T4: state_next_s = S_T5;
      S_T5: begin
        if (cls_s == CLS_MULDIV) state_next_s = S_T6;
        else                     state_next_s = S_DONE;
      end
      S_T6: state_next_s = S_DONE;
      S_DONE: begin
        if (run) state_next_s = S_T0;
        else     state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
        cnt_next_s   = {CNTW{1'b0}};
      end
    endcase
  end

  // Outputs for the step being entered, so the registered copies line up with state_r.
  always_comb begin
    ctl_next_s     = CTL_NONE;
    rin_next_s     = {NREG{1'b0}};
    rout_next_s    = {NREG{1'b0}};
    alu_en_next_s  = 1'b0;
    alu_op_next_s  = {OPW{1'b0}};
    done_next_s    = 1'b0;
    illegal_next_s = 1'b0;
    err_next_s     = 1'b0;
    case (state_next_s)
      S_IDLE: err_next_s = timeout_s;
      S_T0: begin
        ctl_next_s.pc_out = 1'b1;
        ctl_next_s.mar_in = 1'b1;
        ctl_next_s.inc_pc = 1'b1;
        ctl_next_s.z_in   = 1'b1;
      end
      S_T1: begin
        ctl_next_s.zlow_out = 1'b1;
        ctl_next_s.pc_in    = 1'b1;
        ctl_next_s.read     = 1'b1;
        ctl_next_s.mdr_in   = 1'b1;
      end
      S_T2: begin
        ctl_next_s.mdr_out = 1'b1;
        ctl_next_s.ir_in   = 1'b1;
      end
      // IR is only loaded as T3 begins, so the T3 strobes are decoded live below.
      S_T3: ctl_next_s = CTL_NONE;
      S_T4: begin
        rout_next_s     = (cls_s == CLS_BIN) ? reg_sel(rc_s) : reg_sel(rb_s);
        alu_en_next_s   = 1'b1;
        alu_op_next_s   = op_s;
        ctl_next_s.z_in = 1'b1;
      end
      S_T5: begin
        ctl_next_s.zlow_out = 1'b1;
        if (cls_s == CLS_MULDIV) ctl_next_s.lo_in = 1'b1;
        else                     rin_next_s = reg_sel(ra_s);
      end
      S_T6: begin
        ctl_next_s.zhigh_out = 1'b1;
        ctl_next_s.hi_in     = 1'b1;
      end
      S_DONE: begin
        done_next_s    = 1'b1;
        illegal_next_s = (cls_s == CLS_ILLEGAL);
      end
      default: ctl_next_s = CTL_NONE;
    endcase
  end

  // T3 operand fetch into Y, decoded from the freshly loaded IR.
  always_comb begin
    t3_rout_s = {NREG{1'b0}};
    t3_yin_s  = 1'b0;
    if (state_r == S_T3) begin
      case (cls_s)
        CLS_BIN: begin
          t3_rout_s = reg_sel(rb_s);
          t3_yin_s  = 1'b1;
        end
        CLS_MULDIV: begin
          t3_rout_s = reg_sel(ra_s);
          t3_yin_s  = 1'b1;
        end
        default: t3_yin_s = 1'b0;
      endcase
    end else begin
      t3_yin_s = 1'b0;
    end
  end

  // Sequencer state, wait counter and registered control outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CNTW{1'b0}};
      ctl_r     <= CTL_NONE;
      rin_r     <= {NREG{1'b0}};
      rout_r    <= {NREG{1'b0}};
      alu_en_r  <= 1'b0;
      alu_op_r  <= {OPW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      ctl_r     <= ctl_next_s;
      rin_r     <= rin_next_s;
      rout_r    <= rout_next_s;
      alu_en_r  <= alu_en_next_s;
      alu_op_r  <= alu_op_next_s;
      busy_r    <= (state_next_s != S_IDLE);
      done_r    <= done_next_s;
      illegal_r <= illegal_next_s;
      err_r     <= err_next_s;
    end
  end

  assign PCout    = ctl_r.pc_out;
  assign MARin    = ctl_r.mar_in;
  assign IncPC    = ctl_r.inc_pc;
  assign Zin      = ctl_r.z_in;
  assign Zlowout  = ctl_r.zlow_out;
  assign Zhighout = ctl_r.zhigh_out;
  assign PCin     = ctl_r.pc_in;
  assign Read     = ctl_r.read;
  assign MDRin    = ctl_r.mdr_in;
  assign MDRout   = ctl_r.mdr_out;
  assign IRin     = ctl_r.ir_in;
  assign HIin     = ctl_r.hi_in;
  assign LOin     = ctl_r.lo_in;
  assign Yin      = t3_yin_s;
  assign Rin      = rin_r;
  assign Rout     = rout_r | t3_rout_s;
  assign alu_en   = alu_en_r;
  assign alu_op   = alu_op_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign illegal  = illegal_r;
  assign err      = err_r;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: expected per-cycle output vectors are
// queued from an instruction-level model and compared at each falling edge.
module tb_alu_control_sequencer;

  localparam int IRW    = 32;
  localparam int OPW    = 5;
  localparam int REGW   = 4;
  localparam int NREG   = 16;
  localparam int MEM_TO = 15;

  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_MARIN  = 14'h1000;
  localparam logic [13:0] S_INCPC  = 14'h0800;
  localparam logic [13:0] S_ZIN    = 14'h0400;
  localparam logic [13:0] S_ZLOW   = 14'h0200;
  localparam logic [13:0] S_ZHIGH  = 14'h0100;
  localparam logic [13:0] S_PCIN   = 14'h0080;
  localparam logic [13:0] S_READ   = 14'h0040;
  localparam logic [13:0] S_MDRIN  = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010;
  localparam logic [13:0] S_IRIN   = 14'h0008;
  localparam logic [13:0] S_YIN    = 14'h0004;
  localparam logic [13:0] S_HIIN   = 14'h0002;
  localparam logic [13:0] S_LOIN   = 14'h0001;
  localparam logic [55:0] IDLE_V   = 56'd0;

  localparam logic [31:0] IR_AND  = 32'h28918000;  // AND R1,R2,R3
  localparam logic [31:0] IR_NOT  = 32'h90980000;  // NOT R1,R3
  localparam logic [31:0] IR_MUL  = 32'h79180000;  // MUL R2,R3
  localparam logic [31:0] IR_ADD0 = 32'h18228000;  // ADD R0,R4,R5
  localparam logic [31:0] IR_SUB  = 32'h27F68000;  // SUB R15,R14,R13
  localparam logic [31:0] IR_DIV  = 32'h83C00000;  // DIV R7,R8

  logic clk = 1'b0;
  logic clr, start, run, mem_ready;
  logic [IRW-1:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [NREG-1:0] Rin, Rout;
  logic alu_en;
  logic [OPW-1:0] alu_op;
  logic busy, done, illegal, err;

  int checks = 0;
  int errors = 0;
  logic [55:0] sb[$];

  always #5 clk = ~clk;

  alu_control_sequencer #(.IRW(IRW), .OPW(OPW), .REGW(REGW), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .clr(clr), .start(start), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .alu_en(alu_en), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal), .err(err)
  );

  function automatic logic [55:0] obs_vec();
    return {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout,
            IRin, Yin, HIin, LOin, Rin, Rout, alu_en, alu_op, busy, done, illegal, err};
  endfunction

  function automatic logic [55:0] mk(input logic [13:0] s, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic en,
                                     input logic [4:0] op, input logic b, input logic d,
                                     input logic il, input logic e);
    return {s, rin, rout, en, op, b, d, il, e};
  endfunction

  // Instruction-level model: queues one expected vector per cycle from T0 on.
  task automatic push_trace(input logic [31:0] iv, input int waits);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int cls;
    op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
    if (op >= 5'd3 && op <= 5'd10)        cls = 0;
    else if (op == 5'd15 || op == 5'd16)  cls = 1;
    else if (op == 5'd17 || op == 5'd18)  cls = 2;
    else                                  cls = 3;
    sb.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    if (waits >= MEM_TO) begin
      repeat (MEM_TO) sb.push_back(mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk(14'd0, 16'd0, 16'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      repeat (waits + 1) sb.push_back(mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk(S_MDROUT | S_IRIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      if (cls == 0)      sb.push_back(mk(S_YIN, 16'd0, 16'd1 << rb, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      else if (cls == 1) sb.push_back(mk(S_YIN, 16'd0, 16'd1 << ra, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      else               sb.push_back(mk(14'd0, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      if (cls != 3) begin
        sb.push_back(mk(S_ZIN, 16'd0, (cls == 0) ? (16'd1 << rc) : (16'd1 << rb), 1'b1, op, 1'b1, 1'b0, 1'b0, 1'b0));
        if (cls == 1) begin
          sb.push_back(mk(S_ZLOW | S_LOIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
          sb.push_back(mk(S_ZHIGH | S_HIIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        end else begin
          sb.push_back(mk(S_ZLOW, 16'd1 << ra, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
      end
      sb.push_back(mk(14'd0, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b1, (cls == 3), 1'b0));
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = 32'd0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== IDLE_V) begin errors++; $display("FAIL reset_outputs: got %h exp %h", obs_vec(), IDLE_V); end
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== IDLE_V) begin errors++; $display("FAIL reset_holds_start: got %h exp %h", obs_vec(), IDLE_V); end
    clr = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== IDLE_V) begin errors++; $display("FAIL idle_no_start: got %h exp %h", obs_vec(), IDLE_V); end
  endtask

  task automatic test_single(input string name, input logic [31:0] iv, input int exp_done);
    logic [55:0] exp_v;
    int c, done_cyc;
    ir = iv; run = 1'b0; mem_ready = 1'b1;
    push_trace(iv, 0);
    sb.push_back(IDLE_V);
    @(negedge clk); start = 1'b1;
    c = 0; done_cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk); c++; start = 1'b0;
      if (done === 1'b1) done_cyc = c;
      exp_v = sb.pop_front(); checks++;
      if (obs_vec() !== exp_v) begin errors++; $display("FAIL %s_trace cyc%0d: got %h exp %h", name, c, obs_vec(), exp_v); end
    end
    checks++;
    if (done_cyc !== exp_done) begin errors++; $display("FAIL %s_latency: got %0d exp %0d", name, done_cyc, exp_done); end
  endtask

  task automatic test_mem_wait();
    int waits_tab[2] = '{3, 15};
    logic [55:0] exp_v;
    int c, done_cyc, err_cyc, w, exp_done, exp_err;
    for (int i = 0; i < 2; i++) begin
      w = waits_tab[i];
      exp_done = (w < MEM_TO) ? 7 + w : 0;
      exp_err  = (w >= MEM_TO) ? 2 + MEM_TO : 0;
      ir = IR_AND; run = 1'b0; mem_ready = 1'b0;
      push_trace(IR_AND, w);
      sb.push_back(IDLE_V);
      @(negedge clk); start = 1'b1;
      c = 0; done_cyc = 0; err_cyc = 0;
      while (sb.size() > 0) begin
        @(negedge clk); c++; start = 1'b0;
        mem_ready = (c - 2 >= w);
        if (done === 1'b1) done_cyc = c;
        if (err === 1'b1) err_cyc = c;
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin errors++; $display("FAIL memwait%0d_trace cyc%0d: got %h exp %h", w, c, obs_vec(), exp_v); end
      end
      checks++;
      if (done_cyc !== exp_done || err_cyc !== exp_err)
        begin errors++; $display("FAIL memwait%0d_timing: got done@%0d err@%0d exp done@%0d err@%0d", w, done_cyc, err_cyc, exp_done, exp_err); end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_illegal_chain();
    logic [55:0] exp_v;
    int c, ill_cyc;
    logic rin_seen;
    ir = 32'd0; run = 1'b1; mem_ready = 1'b1;
    push_trace(32'd0, 0);
    push_trace(IR_ADD0, 0);
    sb.push_back(IDLE_V);
    @(negedge clk); start = 1'b1;
    c = 0; ill_cyc = 0; rin_seen = 1'b0;
    while (sb.size() > 0) begin
      @(negedge clk); c++; start = 1'b0;
      if (c <= 5 && Rin !== 16'd0) rin_seen = 1'b1;
      if (illegal === 1'b1) ill_cyc = c;
      exp_v = sb.pop_front(); checks++;
      if (obs_vec() !== exp_v) begin errors++; $display("FAIL illegal_chain_trace cyc%0d: got %h exp %h", c, obs_vec(), exp_v); end
      if (c == 5) ir = IR_ADD0;
      if (c == 6) run = 1'b0;
    end
    checks++;
    if (ill_cyc !== 5) begin errors++; $display("FAIL illegal_cycle: got %0d exp 5", ill_cyc); end
    checks++;
    if (rin_seen !== 1'b0) begin errors++; $display("FAIL illegal_rin: got %b exp 0", rin_seen); end
  endtask

  task automatic test_reset_mid();
    logic [55:0] exp_v;
    int c;
    ir = IR_ADD0; run = 1'b0; mem_ready = 1'b1;
    push_trace(IR_ADD0, 0);
    @(negedge clk); start = 1'b1;
    for (c = 1; c <= 5; c++) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (obs_vec() !== exp_v) begin errors++; $display("FAIL midreset_pre cyc%0d: got %h exp %h", c, obs_vec(), exp_v); end
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== IDLE_V) begin errors++; $display("FAIL midreset_async: got %h exp %h", obs_vec(), IDLE_V); end
    sb.delete();
    @(negedge clk); clr = 1'b1;
    test_single("restart", IR_ADD0, 7);
  endtask

  task automatic test_back_to_back();
    logic [55:0] exp_v;
    int c;
    run = 1'b0; mem_ready = 1'b1; ir = IR_SUB;
    push_trace(IR_SUB, 0);
    sb.push_back(IDLE_V);
    push_trace(IR_DIV, 0);
    sb.push_back(IDLE_V);
    @(negedge clk); start = 1'b1;
    c = 0;
    while (sb.size() > 0) begin
      @(negedge clk); c++;
      if (c >= 9) start = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (obs_vec() !== exp_v) begin errors++; $display("FAIL b2b_trace cyc%0d: got %h exp %h", c, obs_vec(), exp_v); end
      if (c == 7) ir = IR_DIV;
    end
  endtask

  initial begin
    test_reset();
    test_single("and", IR_AND, 7);
    test_single("not", IR_NOT, 7);
    test_single("mul", IR_MUL, 8);
    test_mem_wait();
    test_illegal_chain();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks", checks);
    $fatal(1);
  end

endmodule
